// File: rtl/ssd14_scan_ctrl.sv
// ssd14_scan_ctrl: time-multiplexed scan controller for common-enable
// 14-segment digits sharing one BCD-to-14-segment decoder.
// Each digit slot is BLANK_CYC cycles of all-off followed by the digit's
// show window; the shadow digit copy is only updated at the end of a frame.
// Optional feature macro: SSD14_LEADING_ZERO_BLANK_EN (suppress leading zeros).
module ssd14_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic [3:0]              bcd_sel,
  output logic [NUM_DIGITS-1:0]   ssd_ctl,
  output logic                    frame_done
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [IW-1:0]           idx, idx_n;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] stage;
  logic                    pending;
  logic                    commit;
  logic [3:0]              digit_n;
  logic [NUM_DIGITS-1:0]   en_n;
  logic                    show_n;

  // Next-state of the slot sequencer; commit marks the last cycle of a frame.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    commit  = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == CW'(BLANK_CYC - 1)) state_n = SHOW;
      end
      SHOW: begin
        if (cnt == CW'(SCAN_DIV - 1)) begin
          cnt_n   = '0;
          state_n = BLANK;
          if (idx == IW'(NUM_DIGITS - 1)) begin
            idx_n  = '0;
            commit = 1'b1;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      default: state_n = BLANK;
    endcase
  end

`ifdef SSD14_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] sup;
  logic                  zero_run;

  // Leading-zero mask: digit k>0 is suppressed when it and all digits above are zero.
  always_comb begin
    sup      = '0;
    zero_run = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS - 1; i++) begin
      int unsigned k;
      k        = NUM_DIGITS - 1 - i;
      zero_run = zero_run && (shadow[4*k +: 4] == 4'h0);
      sup[k]   = zero_run;
    end
  end
`endif

  // Output values for the cycle being entered; shadow is stable across a
  // whole frame so reading it here gives the same value the next cycle sees.
  always_comb begin
    digit_n = shadow[{idx_n, 2'b00} +: 4];
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      en_n[k] = (idx_n != IW'(k));
    end
`ifdef SSD14_LEADING_ZERO_BLANK_EN
    show_n = (state_n == SHOW) && !sup[idx_n];
`else
    show_n = (state_n == SHOW);
`endif
  end

  // Scan FSM with registered outputs, shadow commit and load staging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '1;
      stage      <= '1;
      pending    <= 1'b0;
      ssd_ctl    <= '1;
      bcd_sel    <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      frame_done <= commit;
      ssd_ctl    <= show_n ? en_n : '1;
      bcd_sel    <= show_n ? digit_n : 4'hF;
      if (load) stage <= bcd_in;
      if (commit) begin
        // A load coinciding with the commit bypasses the stage register.
        if (load)         shadow <= bcd_in;
        else if (pending) shadow <= stage;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ssd14_scan_ctrl.md
Name: ssd14_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-enable 14-segment digits that share one BCD-to-14-segment decoder.
- Holds a tear-free shadow copy of the BCD digits and rotates through them, driving the shared decoder's 4-bit bcd input and the active-low per-digit enables.
- Inserts a blanking gap between digits to suppress ghosting.
- Sits between the counter/datapath logic producing BCD values and the board-level SSD pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; range 2..8.
- SCAN_DIV, 50000: clock cycles per digit slot, blank plus show; must be greater than BLANK_CYC.
- BLANK_CYC, 16: cycles at the start of each slot with all digits off; must be at least 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  single-cycle strobe; capture bcd_in for display.
- bcd_in  input  4*NUM_DIGITS  packed BCD; digit k = bcd_in[4k+3:4k]; digit 0 is least significant.
- bcd_sel  output  4  to the shared decoder's bcd input; 4'hF means blank (decoder default, all segments off).
- ssd_ctl  output  NUM_DIGITS  active-low digit enables; bit k enables digit k.
- frame_done  output  1  one-cycle pulse at the end of each full scan frame.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All outputs are registered.
- Reset values:
  - ssd_ctl all 1, bcd_sel = 4'hF, frame_done = 0.
  - Shadow digits all 4'hF; stage register all 4'hF; pending = 0.
  - idx = 0, state = BLANK, slot counter cnt = 0.
- Reset mid-operation: takes effect immediately (asynchronous). The display is blank in the same cycle and any pending load is discarded.
- FSM states: BLANK, SHOW. cnt counts 0..SCAN_DIV-1 within each slot.
- BLANK (cnt 0..BLANK_CYC-1):
  - ssd_ctl all 1, bcd_sel = 4'hF.
  - At cnt = BLANK_CYC-1, go to SHOW.
- SHOW (cnt BLANK_CYC..SCAN_DIV-1):
  - ssd_ctl bit idx = 0, all other bits 1.
  - bcd_sel = shadow[idx].
  - At cnt = SCAN_DIV-1: cnt <= 0, state <= BLANK, idx <= idx+1, wrapping from NUM_DIGITS-1 to 0.
- Timing: slot length = SCAN_DIV cycles; frame length = NUM_DIGITS*SCAN_DIV cycles.
- Output registration: outputs reflect state/cnt/idx, so they change one cycle after the registered transition is taken.
- frame_done: asserted for exactly one cycle, in the first BLANK cycle of digit 0 following a wrap. It is never asserted during the first slot after reset.
- Load/commit:
  - On load, stage <= bcd_in and pending <= 1. If several loads arrive before a commit, the last one wins.
  - The commit point is the SHOW cycle at cnt = SCAN_DIV-1 with idx = NUM_DIGITS-1. At that edge:
    - If load is high in that same cycle, shadow <= bcd_in directly.
    - Otherwise, if pending = 1, shadow <= stage.
    - pending <= 0 in either case.
  - Shadow never changes mid-frame, so every frame shows one consistent value.
- Codes 10..15: passed through unchanged on bcd_sel; the decoder blanks them.
- Arithmetic: cnt width = clog2(SCAN_DIV); idx width = clog2(NUM_DIGITS), minimum 1. Wrap is explicit; no reliance on power-of-2 overflow.

Optional Feature:
- Macro: SSD14_LEADING_ZERO_BLANK_EN.
- Defined:
  - In SHOW, a digit k > 0 is suppressed when shadow[k] and every shadow digit above k equal 4'h0.
  - A suppressed digit keeps ssd_ctl all 1 and bcd_sel = 4'hF for its whole slot.
  - Digit 0 is never suppressed.
  - The suppression mask is computed from shadow only, and is therefore also tear-free.
- Undefined: all digits are displayed as-is, including leading zeros.

Test Plan (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2):
- Reset, no load -> ssd_ctl=4'b1111, bcd_sel=4'hF, frame_done=0 during reset. After release, the first frame_done arrives 32 cycles later and then every 32 cycles, each a 1-cycle pulse.
- Load 16'h1234 in the first slot -> the next frame shows, per slot, 2 blank cycles then 6 cycles of (ssd_ctl, bcd_sel) = (1110, 4), (1101, 3), (1011, 2), (0111, 1).
- Load 16'h1234, then load 16'h5678 during the digit-1 slot of the next frame -> digits 2 and 3 still show 2 and 1; the following frame shows 8, 7, 6, 5.
- Load 16'h9999 on the exact commit cycle, with pending stage 16'h1111 -> the next frame shows 9, 9, 9, 9.
- Assert rst during SHOW of digit 2 -> outputs go to 1111/F in the same cycle. After release, scanning restarts at digit 0 BLANK with a blank shadow, and the pending load is lost.
- With SSD14_LEADING_ZERO_BLANK_EN defined:
  - 16'h0040 -> digit 3 and digit 2 slots have ssd_ctl=1111; digit 1 shows 4; digit 0 shows 0.
  - 16'h0000 -> only digit 0 is lit, showing 0.
